// File: rtl/prbs_cfg_sequencer_pkg.sv
// Shared definitions for the PRBS configuration sequencer: byte map,
// field mask bit positions, state encoding and byte-image helpers.
package prbs_cfg_sequencer_pkg;

  localparam int NUM_CFG_BYTES = 10;
  localparam int IDX_W         = 4;

  // Byte offsets relative to BASE_ADDR
  localparam int OFS_PN        = 0;
  localparam int OFS_BIT_RATE  = 1;
  localparam int OFS_EDGE      = 5;
  localparam int OFS_AMPLITUDE = 6;
  localparam int OFS_DC_OFFSET = 8;

  // Positions in cmd_field_mask
  localparam int MSK_PN        = 0;
  localparam int MSK_BIT_RATE  = 1;
  localparam int MSK_EDGE      = 2;
  localparam int MSK_AMPLITUDE = 3;
  localparam int MSK_DC_OFFSET = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_GAP,
    ST_HOLD,
    ST_ABORT,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic [4:0]  pn_select;
    logic [31:0] bit_rate;
    logic [7:0]  edge_time;
    logic [15:0] amplitude;
    logic [15:0] dc_offset;
  } cfg_fields_t;

  typedef logic [NUM_CFG_BYTES-1:0][7:0] cfg_bytes_t;

  // Byte image of a command as it lands in the register bank (multi-byte fields LSB first)
  function automatic cfg_bytes_t build_cfg_bytes(input cfg_fields_t f);
    cfg_bytes_t b;
    b = '0;
    b[OFS_PN] = {3'b000, f.pn_select};
    for (int k = 0; k < 4; k++) b[OFS_BIT_RATE+k] = f.bit_rate[8*k +: 8];
    b[OFS_EDGE] = f.edge_time;
    for (int k = 0; k < 2; k++) begin
      b[OFS_AMPLITUDE+k] = f.amplitude[8*k +: 8];
      b[OFS_DC_OFFSET+k] = f.dc_offset[8*k +: 8];
    end
    return b;
  endfunction

  // Expand the per-field mask into one enable bit per byte
  function automatic logic [NUM_CFG_BYTES-1:0] mask_to_byte_en(input logic [4:0] mask);
    logic [NUM_CFG_BYTES-1:0] en;
    en = '0;
    en[OFS_PN]               = mask[MSK_PN];
    en[OFS_BIT_RATE +: 4]    = {4{mask[MSK_BIT_RATE]}};
    en[OFS_EDGE]             = mask[MSK_EDGE];
    en[OFS_AMPLITUDE +: 2]   = {2{mask[MSK_AMPLITUDE]}};
    en[OFS_DC_OFFSET +: 2]   = {2{mask[MSK_DC_OFFSET]}};
    return en;
  endfunction

endpackage

// File: rtl/prbs_cfg_byte_mux.sv
// Priority pick of the lowest-offset enabled configuration byte, giving
// its index, bus address and data.
module prbs_cfg_byte_mux
  import prbs_cfg_sequencer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h20
) (
  input  logic [NUM_CFG_BYTES-1:0] byte_en,
  input  cfg_fields_t              fields,
  output logic [IDX_W-1:0]         pick_idx,
  output logic [7:0]               pick_addr,
  output logic [7:0]               pick_data
);

  cfg_bytes_t cfg_bytes;

  assign cfg_bytes = build_cfg_bytes(fields);

  // Scan downwards so the lowest enabled offset wins
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_CFG_BYTES - 1; i >= 0; i--) begin
      if (byte_en[i]) pick_idx = IDX_W'(i);
    end
    pick_addr = BASE_ADDR + 8'(pick_idx);
    pick_data = cfg_bytes[pick_idx];
  end

endmodule

// File: rtl/prbs_cfg_sequencer.sv
// Serialises a masked PRBS parameter update into byte writes on the channel
// configuration bus, stalling while the bank is load-protected.
// Optional build macro PRBS_CFG_SKIP_UNCHANGED_EN: keep a shadow of every
// written byte and drop enabled bytes whose value already matches it.
//
// state  | meaning
// IDLE   | ready for a command
// LOAD   | build byte enables from the latched mask, launch first byte
// WRITE  | CH_CONFIG_WE high for one byte this cycle
// GAP    | idle spacing between byte writes
// HOLD   | byte pending, bank protected; stall timer running
// ABORT  | stall timeout, err_timeout pulse, remaining bytes dropped
// DONE   | done pulse
//
// The protect input is sampled at the edge that would launch a byte, so the
// strobe itself comes straight from a flop.
module prbs_cfg_sequencer
  import prbs_cfg_sequencer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = 8'h20,
  parameter int unsigned WR_GAP          = 1,
  parameter int unsigned PROTECT_TIMEOUT = 1024
) (
  input  logic        CLK_LOW,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_field_mask,
  input  logic [4:0]  cmd_pn_select,
  input  logic [31:0] cmd_bit_rate,
  input  logic [7:0]  cmd_edge_time,
  input  logic [15:0] cmd_amplitude,
  input  logic [15:0] cmd_dc_offset,
  input  logic        CH_LOAD_PROTECT_STATE,
  output logic        CH_CONFIG_WE,
  output logic [7:0]  CH_CONFIG_ADDR,
  output logic [7:0]  CH_CONFIG_DATA,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int SW = (PROTECT_TIMEOUT > 1) ? $clog2(PROTECT_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LOAD   = (WR_GAP > 0) ? GW'(WR_GAP - 1) : '0;
  localparam logic [SW-1:0] STALL_LOAD = SW'(PROTECT_TIMEOUT - 1);

  seq_state_t               state;
  cfg_fields_t              fields_q;
  logic [4:0]               mask_q;
  logic [NUM_CFG_BYTES-1:0] en_q;
  logic [NUM_CFG_BYTES-1:0] load_en;
  logic [NUM_CFG_BYTES-1:0] cur_en;
  logic [NUM_CFG_BYTES-1:0] skip_en;
  logic [IDX_W-1:0]         pick_idx;
  logic [7:0]               pick_addr;
  logic [7:0]               pick_data;
  logic [GW-1:0]            gap_cnt;
  logic [SW-1:0]            stall_cnt;
  logic                     issue_point;
  logic                     launch;

  assign load_en = mask_to_byte_en(mask_q) & ~skip_en;
  assign cur_en  = (state == ST_LOAD) ? load_en : en_q;

  prbs_cfg_byte_mux #(
    .BASE_ADDR (BASE_ADDR)
  ) u_byte_mux (
    .byte_en   (cur_en),
    .fields    (fields_q),
    .pick_idx  (pick_idx),
    .pick_addr (pick_addr),
    .pick_data (pick_data)
  );

  // Cycles whose closing edge would launch the next byte
  always_comb begin
    issue_point = 1'b0;
    case (state)
      ST_LOAD:  issue_point = (load_en != '0);
      ST_WRITE: issue_point = (WR_GAP == 0) && (en_q != '0);
      ST_GAP:   issue_point = (gap_cnt == '0);
      ST_HOLD:  issue_point = 1'b1;
      default:  issue_point = 1'b0;
    endcase
  end

  assign launch = issue_point && !CH_LOAD_PROTECT_STATE;

`ifdef PRBS_CFG_SKIP_UNCHANGED_EN
  cfg_bytes_t               shadow_val;
  logic [NUM_CFG_BYTES-1:0] shadow_vld;
  cfg_bytes_t               cur_bytes;

  assign cur_bytes = build_cfg_bytes(fields_q);

  // Bytes already holding the requested value in the bank are dropped
  always_comb begin
    skip_en = '0;
    for (int i = 0; i < NUM_CFG_BYTES; i++) begin
      skip_en[i] = shadow_vld[i] && (shadow_val[i] == cur_bytes[i]);
    end
  end

  // Shadow follows every byte launched onto the bus
  always_ff @(posedge CLK_LOW or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_vld <= '0;
    end else if (launch) begin
      shadow_val[pick_idx] <= pick_data;
      shadow_vld[pick_idx] <= 1'b1;
    end
  end
`else
  assign skip_en = '0;
`endif

  // Sequencer state, counters and registered bus/status outputs
  always_ff @(posedge CLK_LOW or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      fields_q       <= '0;
      mask_q         <= '0;
      en_q           <= '0;
      gap_cnt        <= '0;
      stall_cnt      <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      CH_CONFIG_WE   <= 1'b0;
      CH_CONFIG_ADDR <= '0;
      CH_CONFIG_DATA <= '0;
    end else begin
      CH_CONFIG_WE <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            fields_q  <= '{pn_select: cmd_pn_select, bit_rate: cmd_bit_rate,
                           edge_time: cmd_edge_time, amplitude: cmd_amplitude,
                           dc_offset: cmd_dc_offset};
            mask_q    <= cmd_field_mask;
            state     <= ST_LOAD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          en_q <= load_en;
          if (load_en == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (en_q == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (WR_GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        ST_HOLD: begin
          if (CH_LOAD_PROTECT_STATE) begin
            if (stall_cnt == '0) begin
              state       <= ST_ABORT;
              err_timeout <= 1'b1;
              en_q        <= '0;
            end else begin
              stall_cnt <= stall_cnt - 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          en_q      <= '0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase

      if (issue_point) begin
        if (launch) begin
          state          <= ST_WRITE;
          CH_CONFIG_WE   <= 1'b1;
          CH_CONFIG_ADDR <= pick_addr;
          CH_CONFIG_DATA <= pick_data;
          en_q           <= cur_en & ~(NUM_CFG_BYTES'(1) << pick_idx);
        end else if (state != ST_HOLD) begin
          state     <= ST_HOLD;
          stall_cnt <= STALL_LOAD;
        end
      end
    end
  end

endmodule
